// File: rtl/fifo_flow_ctrl_fsm.sv
// Flow-control FSM for a bank of NUM_CH TLP FIFOs: per-channel pause/continue with hold-time hysteresis.
// Optional FLOW_ERR_COUNT_EN adds a saturating err_count output. The continue port is named cont (reserved word).
module fifo_flow_ctrl_fsm #(
    parameter int NUM_CH    = 4,
    parameter int MIN_PAUSE = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              err_clear,
    input  logic [NUM_CH-1:0] fifo_pause,
    input  logic [NUM_CH-1:0] fifo_continue,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_error,
    output logic [NUM_CH-1:0] error_full,
    output logic [NUM_CH-1:0] pause,
    output logic [NUM_CH-1:0] cont,
    output logic              idle,
    output logic              active,
`ifdef FLOW_ERR_COUNT_EN
    output logic [ERR_CNT_W-1:0] err_count,
`endif
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACTIVE = 3'd2,
        S_PAUSE  = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [7:0] MIN_HOLD = 8'(MIN_PAUSE);

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0]       pause_q, pause_d;
    logic [NUM_CH-1:0]       ef_q, ef_d;
    logic [NUM_CH-1:0][7:0]  hold_q, hold_d;
    logic [NUM_CH-1:0]       chan_pause;
    logic [NUM_CH-1:0][7:0]  chan_hold;
    logic                    err_any;
    logic                    state_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            pause_q <= '0;
            ef_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            ef_q    <= ef_d;
            hold_q  <= hold_d;
        end
    end

    // Per-channel hysteresis: a pause is only released after being held MIN_PAUSE edges.
    always_comb begin
        chan_pause = pause_q;
        chan_hold  = hold_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pause_q[i]) begin
                if (fifo_continue[i] && !fifo_pause[i] && (hold_q[i] >= MIN_HOLD)) begin
                    chan_pause[i] = 1'b0;
                    chan_hold[i]  = 8'd0;
                end else if (hold_q[i] < MIN_HOLD) begin
                    chan_hold[i] = hold_q[i] + 8'd1;
                end
            end else if (fifo_pause[i]) begin
                chan_pause[i] = 1'b1;
                chan_hold[i]  = 8'd0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pause_d     = pause_q;
        ef_d        = ef_q;
        hold_d      = hold_q;
        err_any     = |(fifo_error | fifo_full);
        state_valid = state_q inside {S_INIT, S_IDLE, S_ACTIVE, S_PAUSE, S_ERROR};

        if (init) begin
            state_d = S_INIT;
            pause_d = '0;
            ef_d    = '0;
            hold_d  = '0;
        end else if (!state_valid || (state_q == S_INIT)) begin
            // Unused encodings fall back to INIT; INIT itself ignores FIFO errors.
            state_d = (state_q == S_INIT) ? S_IDLE : S_INIT;
            pause_d = '0;
            ef_d    = '0;
            hold_d  = '0;
        end else if (err_any) begin
            state_d = S_ERROR;
            pause_d = '1;
            ef_d    = ef_q | fifo_error | fifo_full;
            hold_d  = '0;
        end else if (state_q == S_ERROR) begin
            if (err_clear) begin
                state_d = S_IDLE;
                pause_d = '0;
                ef_d    = '0;
                hold_d  = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    pause_d = '0;
                    hold_d  = '0;
                    if (!(&fifo_empty)) state_d = S_ACTIVE;
                end
                S_ACTIVE: begin
                    pause_d = chan_pause;
                    hold_d  = chan_hold;
                    if (|chan_pause)      state_d = S_PAUSE;
                    else if (&fifo_empty) state_d = S_IDLE;
                end
                S_PAUSE: begin
                    pause_d = chan_pause;
                    hold_d  = chan_hold;
                    if (!(|chan_pause)) state_d = S_ACTIVE;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

`ifdef FLOW_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Counts entries into ERROR only; err_clear deliberately leaves the history intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (init || (state_q == S_INIT)) begin
            err_cnt_q <= '0;
        end else if ((state_d == S_ERROR) && (state_q != S_ERROR) && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign state      = state_q;
    assign pause      = pause_q;
    assign error_full = ef_q;
    assign idle       = (state_q == S_IDLE);
    assign active     = (state_q == S_ACTIVE) || (state_q == S_PAUSE);
    assign cont       = ((state_q == S_IDLE) || (state_q == S_ACTIVE) || (state_q == S_PAUSE))
                        ? ~pause_q : '0;

endmodule
